// File: rtl/uart_byte_fifo_if.sv
//==============================================================================
// Module  : uart_byte_fifo_if
// Brief   : RX-capture / TX-handshake / status bundle for uart_byte_fifo.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

interface uart_byte_fifo_if #(
    parameter int p_COUNT_W = 5
);
    logic                 i_Rx_State;
    logic [7:0]           i_Rx_Byte;
    logic [7:0]           o_Tx_Byte;
    logic                 o_Tx_Ready;
    logic                 i_Tx_Completed;
    logic [p_COUNT_W-1:0] o_Count;
    logic                 o_Empty;
    logic                 o_Full;
    logic                 o_Overflow;

    // master: the surrounding UART RX/TX logic; slave: the FIFO itself
    modport master (
        output i_Rx_State, i_Rx_Byte, i_Tx_Completed,
        input  o_Tx_Byte, o_Tx_Ready, o_Count, o_Empty, o_Full, o_Overflow
    );

    modport slave (
        input  i_Rx_State, i_Rx_Byte, i_Tx_Completed,
        output o_Tx_Byte, o_Tx_Ready, o_Count, o_Empty, o_Full, o_Overflow
    );
endinterface

`default_nettype wire

// File: rtl/uart_byte_fifo.sv
//==============================================================================
// Module  : uart_byte_fifo
// Brief   : Elastic byte FIFO in the UART echo path; captures RX bytes on the
//           byte-valid rising edge and feeds TX via a Ready/Completed handshake.
//           Define UART_FIFO_OVERWRITE_EN to overwrite the oldest byte when full.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_byte_fifo #(
    parameter int p_DEPTH_LOG2 = 4,
    parameter int p_COUNT_W    = p_DEPTH_LOG2 + 1
) (
    input  wire logic        i_Clk,
    input  wire logic        i_Reset,
    uart_byte_fifo_if.slave  fifo_if
);

    localparam int                   c_DEPTH_N = 1 << p_DEPTH_LOG2;
    localparam logic [p_COUNT_W-1:0] c_DEPTH   = p_COUNT_W'(c_DEPTH_N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_START = 2'd2,
        S_BUSY  = 2'd3
    } state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [7:0]              r_mem [0:c_DEPTH_N-1];
    logic [p_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [p_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [p_COUNT_W-1:0]    r_count;
    logic                    r_rx_prev;
    logic                    r_overflow;
    logic [7:0]              r_tx_byte;

    logic w_wr_en;
    logic w_load;
    logic w_full;
    logic w_wr_accept;
    logic w_wr_block;
    logic w_mem_we;
    logic w_rd_skip;

    assign w_wr_en     = fifo_if.i_Rx_State & ~r_rx_prev;
    assign w_load      = (r_state == S_LOAD);
    assign w_full      = (r_count == c_DEPTH);
    // A LOAD in the same cycle frees a slot, so a full FIFO can still accept
    assign w_wr_accept = w_wr_en & (~w_full | w_load);
    assign w_wr_block  = w_wr_en & w_full & ~w_load;

`ifdef UART_FIFO_OVERWRITE_EN
    assign w_mem_we  = w_wr_accept | w_wr_block;
    assign w_rd_skip = w_wr_block;
`else
    assign w_mem_we  = w_wr_accept;
    assign w_rd_skip = 1'b0;
`endif

    always_ff @(posedge i_Clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr] <= fifo_if.i_Rx_Byte;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rx_prev  <= 1'b0;
            r_overflow <= 1'b0;
            r_tx_byte  <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_rx_prev <= fifo_if.i_Rx_State;
            if (w_mem_we) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load | w_rd_skip) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_load) begin
                r_tx_byte <= r_mem[r_rd_ptr];
            end
            if (w_wr_accept && !w_load) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr_accept && w_load) begin
                r_count <= r_count - 1'b1;
            end
            if (w_wr_block) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (r_count != '0) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_START;
            S_START: w_state_nxt = S_BUSY;
            S_BUSY:  if (fifo_if.i_Tx_Completed) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign fifo_if.o_Tx_Byte  = r_tx_byte;
    assign fifo_if.o_Tx_Ready = (r_state == S_START);
    assign fifo_if.o_Count    = r_count;
    assign fifo_if.o_Empty    = (r_count == '0);
    assign fifo_if.o_Full     = w_full;
    assign fifo_if.o_Overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_uart_byte_fifo.sv
//==============================================================================
// Module  : tb_uart_byte_fifo
// Brief   : Self-checking bench for uart_byte_fifo (vector table, corner
//           sequences, randomized traffic against a queue reference model).
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_byte_fifo;

    logic clk;
    logic rst;

    uart_byte_fifo_if #(.p_COUNT_W(5)) bus ();

    uart_byte_fifo #(
        .p_DEPTH_LOG2 (4),
        .p_COUNT_W    (5)
    ) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .fifo_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ready_cnt = 0;

    always @(negedge clk) begin
        if (bus.o_Tx_Ready === 1'b1) ready_cnt++;
    end

    typedef struct {
        logic       rx;
        logic [7:0] rxb;
        logic       cmp;
        logic [4:0] e_count;
        logic       e_empty;
        logic       e_ready;
        logic [7:0] e_txb;
    } vec_t;

    vec_t vt [12];

    function automatic vec_t mk(logic rx, logic [7:0] rxb, logic cmp, logic [4:0] ec,
                                logic ee, logic er, logic [7:0] et);
        vec_t v;
        v.rx = rx; v.rxb = rxb; v.cmp = cmp; v.e_count = ec;
        v.e_empty = ee; v.e_ready = er; v.e_txb = et;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_Rx_State = 1'b0;
        bus.i_Rx_Byte = 8'h00;
        bus.i_Tx_Completed = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_Rx_State = 1'b1;
        bus.i_Rx_Byte = b;
        tick();
        bus.i_Rx_State = 1'b0;
        tick();
    endtask

    task automatic wait_ready(input logic [7:0] exp, input string name);
        bit seen = 0;
        for (int t = 0; t < 12 && !seen; t++) begin
            tick();
            if (bus.o_Tx_Ready === 1'b1) begin
                seen = 1;
                check(name, {24'h0, bus.o_Tx_Byte}, {24'h0, exp});
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s actual=no_ready required=ready_within_12_cycles", name);
        end
    endtask

    // Finish the transfer currently in BUSY, then expect the next byte
    task automatic drain_one(input logic [7:0] exp, input string name);
        tick();
        bus.i_Tx_Completed = 1'b1;
        tick();
        bus.i_Tx_Completed = 1'b0;
        wait_ready(exp, name);
    endtask

    logic [7:0] model_q [$];
    logic [7:0] b;
    logic [7:0] e;
    int writes, readies, comps, cd, rc;
    bit busy_tx;

    initial begin
        vt[0]  = mk(1'b1, 8'hA5, 1'b0, 5'd1, 1'b0, 1'b0, 8'h00);
        vt[1]  = mk(1'b1, 8'hA5, 1'b0, 5'd1, 1'b0, 1'b0, 8'h00);
        vt[2]  = mk(1'b1, 8'hA5, 1'b0, 5'd0, 1'b1, 1'b1, 8'hA5);
        for (int i = 3; i < 10; i++) vt[i] = mk(1'b1, 8'hA5, 1'b0, 5'd0, 1'b1, 1'b0, 8'hA5);
        vt[10] = mk(1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 8'hA5);
        vt[11] = mk(1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 8'hA5);

        // Reset values, checked while reset is still asserted
        rst = 1'b1;
        bus.i_Rx_State = 1'b0;
        bus.i_Rx_Byte = 8'h00;
        bus.i_Tx_Completed = 1'b0;
        tick();
        check("rst_count", 32'(bus.o_Count), 32'd0);
        check("rst_empty", 32'(bus.o_Empty), 32'd1);
        check("rst_full", 32'(bus.o_Full), 32'd0);
        check("rst_overflow", 32'(bus.o_Overflow), 32'd0);
        check("rst_ready", 32'(bus.o_Tx_Ready), 32'd0);
        check("rst_txbyte", 32'(bus.o_Tx_Byte), 32'd0);
        rst = 1'b0;

        // Idle 50 cycles
        rc = ready_cnt;
        repeat (50) tick();
        check("idle_ready_pulses", ready_cnt - rc, 32'd0);
        check("idle_count", 32'(bus.o_Count), 32'd0);
        check("idle_empty", 32'(bus.o_Empty), 32'd1);
        check("idle_txbyte", 32'(bus.o_Tx_Byte), 32'd0);

        // Single byte 0xA5 held high 10 cycles (table)
        rc = ready_cnt;
        for (int i = 0; i < 12; i++) begin
            bus.i_Rx_State = vt[i].rx;
            bus.i_Rx_Byte = vt[i].rxb;
            bus.i_Tx_Completed = vt[i].cmp;
            tick();
            check($sformatf("vec%0d_count", i), 32'(bus.o_Count), 32'(vt[i].e_count));
            check($sformatf("vec%0d_empty", i), 32'(bus.o_Empty), 32'(vt[i].e_empty));
            check($sformatf("vec%0d_ready", i), 32'(bus.o_Tx_Ready), 32'(vt[i].e_ready));
            check($sformatf("vec%0d_txbyte", i), 32'(bus.o_Tx_Byte), 32'(vt[i].e_txb));
        end
        check("single_ready_pulses", ready_cnt - rc, 32'd1);

        // Burst 0x01..0x05 with TX stalled on 0x01
        do_reset();
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        check("burst_peak_count", 32'(bus.o_Count), 32'd4);
        rc = ready_cnt;
        for (int i = 2; i <= 5; i++) drain_one(8'(i), $sformatf("burst_byte%0d", i));
        tick();
        bus.i_Tx_Completed = 1'b1;
        tick();
        bus.i_Tx_Completed = 1'b0;
        repeat (10) tick();
        check("burst_ready_per_completed", ready_cnt - rc, 32'd4);
        check("burst_final_count", 32'(bus.o_Count), 32'd0);

        // 17 bytes into a 16-deep FIFO while TX is busy with a filler byte
        do_reset();
        send_byte(8'hEE);
        repeat (3) tick();
        for (int i = 0; i < 17; i++) send_byte(8'(8'h10 + i));
        check("ovf_count", 32'(bus.o_Count), 32'd16);
        check("ovf_full", 32'(bus.o_Full), 32'd1);
        check("ovf_flag", 32'(bus.o_Overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
`ifdef UART_FIFO_OVERWRITE_EN
            drain_one(8'(8'h11 + i), $sformatf("ovf_drain%0d", i));
`else
            drain_one(8'(8'h10 + i), $sformatf("ovf_drain%0d", i));
`endif
        end
        check("ovf_drained_empty", 32'(bus.o_Empty), 32'd1);
        check("ovf_sticky", 32'(bus.o_Overflow), 32'd1);

        // Write coinciding with LOAD while full; exercises pointer wrap
        do_reset();
        send_byte(8'hEE);
        repeat (3) tick();
        for (int i = 0; i < 16; i++) send_byte(8'(8'h30 + i));
        check("wl_pre_count", 32'(bus.o_Count), 32'd16);
        check("wl_pre_overflow", 32'(bus.o_Overflow), 32'd0);
        bus.i_Tx_Completed = 1'b1;
        tick();
        bus.i_Tx_Completed = 1'b0;
        tick();
        bus.i_Rx_State = 1'b1;
        bus.i_Rx_Byte = 8'h40;
        tick();
        bus.i_Rx_State = 1'b0;
        check("wl_count", 32'(bus.o_Count), 32'd16);
        check("wl_full", 32'(bus.o_Full), 32'd1);
        check("wl_overflow", 32'(bus.o_Overflow), 32'd0);
        check("wl_ready", 32'(bus.o_Tx_Ready), 32'd1);
        check("wl_txbyte", 32'(bus.o_Tx_Byte), 32'h30);
        for (int i = 1; i <= 16; i++) drain_one(8'(8'h30 + i), $sformatf("wl_drain%0d", i));
        check("wl_drained_empty", 32'(bus.o_Empty), 32'd1);

        // Asynchronous reset during BUSY with three bytes queued
        do_reset();
        send_byte(8'h55);
        repeat (3) tick();
        for (int i = 0; i < 3; i++) send_byte(8'(8'h60 + i));
        check("mid_pre_count", 32'(bus.o_Count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_count", 32'(bus.o_Count), 32'd0);
        check("mid_rst_empty", 32'(bus.o_Empty), 32'd1);
        check("mid_rst_txbyte", 32'(bus.o_Tx_Byte), 32'd0);
        check("mid_rst_ready", 32'(bus.o_Tx_Ready), 32'd0);
        tick();
        rst = 1'b0;
        rc = ready_cnt;
        bus.i_Tx_Completed = 1'b1;
        tick();
        bus.i_Tx_Completed = 1'b0;
        repeat (10) tick();
        check("mid_late_completed_ready", ready_cnt - rc, 32'd0);
        check("mid_late_count", 32'(bus.o_Count), 32'd0);

        // Randomized traffic against a queue model (never allowed to fill)
        do_reset();
        model_q.delete();
        writes = 0; readies = 0; comps = 0; cd = 0; busy_tx = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            bus.i_Tx_Completed = 1'b0;
            if (bus.o_Tx_Ready === 1'b1) begin
                readies++;
                if (model_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_unexpected_ready actual=%0h required=no_ready", bus.o_Tx_Byte);
                end else begin
                    e = model_q.pop_front();
                    check("rand_txbyte", 32'(bus.o_Tx_Byte), 32'(e));
                end
                check("rand_count", 32'(bus.o_Count), 32'(writes - readies));
                check("rand_empty", 32'(bus.o_Empty), 32'((writes - readies) == 0));
                busy_tx = 1;
                cd = $urandom_range(1, 6);
            end else if (busy_tx) begin
                cd--;
                if (cd == 0) begin
                    bus.i_Tx_Completed = 1'b1;
                    busy_tx = 0;
                    comps++;
                end
            end
            if (bus.i_Rx_State) begin
                bus.i_Rx_State = 1'b0;
            end else if (cyc < 2600 && (writes - comps) < 12 && $urandom_range(0, 2) == 0) begin
                b = 8'($urandom);
                bus.i_Rx_State = 1'b1;
                bus.i_Rx_Byte = b;
                model_q.push_back(b);
                writes++;
            end
        end
        check("rand_model_drained", 32'(model_q.size()), 32'd0);
        check("rand_all_sent", 32'(readies), 32'(writes));
        check("rand_final_overflow", 32'(bus.o_Overflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
